// File: rtl/ahb_master_sequencer_pkg.sv
// ahb_pkg: AHB-Lite encodings and sequencer state type
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_BURST, ST_LAST, ST_DONE} state_e;
  function automatic logic [31:0] size_inc(input logic [1:0] s);
    return 32'd1 << s;
  endfunction
endpackage

// File: rtl/ahb_master_sequencer_if.sv
// ahb_master_sequencer_if: AHB-Lite signals between the sequencer and the bridge
interface ahb_master_sequencer_if;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Hrdata;
  logic        Hwrite;
  logic        Hreadyin;
  logic        Hreadyout;
  logic [2:0]  Hsize;
  logic [2:0]  Hburst;
  logic [1:0]  Htrans;
  modport master (
    output Haddr, Hwdata, Hwrite, Hsize, Hburst, Htrans, Hreadyin,
    input  Hreadyout, Hrdata
  );
  modport slave (
    input  Haddr, Hwdata, Hwrite, Hsize, Hburst, Htrans, Hreadyin,
    output Hreadyout, Hrdata
  );
endinterface

// File: rtl/ahb_master_sequencer_addr_gen.sv
// ahb_addr_gen: command legality checks and the registered beat address
module ahb_addr_gen
  import ahb_pkg::*;
#(
  parameter int BOUNDARY = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [2:0]  cmd_len,
  input  logic [1:0]  cur_size,
  output logic [31:0] addr_q,
  output logic        bad
);
  logic [31:0] cmd_inc, last_addr, addr_d;
  // a wrapped end address also counts as a boundary crossing
  always_comb begin
    cmd_inc   = size_inc(cmd_size);
    last_addr = cmd_addr + 32'(cmd_len) * cmd_inc;
    bad       = {1'b0, cmd_size} > HSIZE_WORD || (cmd_addr & (cmd_inc - 32'd1)) != 32'd0 ||
                cmd_addr / BOUNDARY != last_addr / BOUNDARY || last_addr < cmd_addr;
    addr_d    = load ? cmd_addr : step ? addr_q + size_inc(cur_size) : addr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) addr_q <= '0;
    else addr_q <= addr_d;
endmodule

// File: rtl/ahb_master_sequencer.sv
// ahb_master_sequencer: turns single commands into pipelined AHB-Lite SINGLE/INCR/INCR4 transfers
module ahb_master_sequencer
  import ahb_pkg::*;
#(
  parameter int MAX_BEATS = 4,
  parameter int BOUNDARY  = 1024
) (
  input  logic                    Hclk,
  input  logic                    Hresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [31:0]             cmd_addr,
  input  logic [1:0]              cmd_size,
  input  logic [2:0]              cmd_len,
  input  logic [32*MAX_BEATS-1:0] cmd_wdata,
  output logic                    rd_valid,
  output logic [31:0]             rd_data,
  output logic                    done,
  output logic                    err,
  output logic                    busy,
  ahb_master_sequencer_if.master  ahb
);
  localparam int CW = MAX_BEATS > 1 ? $clog2(MAX_BEATS) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [MAX_BEATS-1:0][31:0] wdata_q, wdata_d;
  logic [31:0] hwdata_q, hwdata_d, rd_data_q, rd_data_d, addr_q;
  logic [2:0] burst_q, burst_d;
  logic [1:0] size_q, size_d;
  logic write_q, write_d, rd_valid_q, rd_valid_d, err_q, err_d, hreadyin_q;
  logic accept, bad_addr, bad, last_beat, addr_adv, data_end, step;
  assign accept    = cmd_valid && cmd_ready;
  assign bad       = bad_addr || int'(cmd_len) >= MAX_BEATS;
  assign last_beat = cnt_q == len_q;
  assign addr_adv  = ahb.Hreadyout && (state_q == ST_ADDR || state_q == ST_BURST);
  assign data_end  = ahb.Hreadyout && (state_q == ST_BURST || state_q == ST_LAST);
  assign step      = addr_adv && !last_beat;
  ahb_addr_gen #(.BOUNDARY(BOUNDARY)) u_addr_gen (
    .clk      (Hclk),
    .rst_n    (Hresetn),
    .load     (accept),
    .step     (step),
    .cmd_addr (cmd_addr),
    .cmd_size (cmd_size),
    .cmd_len  (cmd_len),
    .cur_size (size_q),
    .addr_q   (addr_q),
    .bad      (bad_addr)
  );
  always_ff @(posedge Hclk or negedge Hresetn)
    if (!Hresetn) state_q <= ST_IDLE;
    else state_q <= state_d;
  // DONE behaves like IDLE for acceptance so a new command can follow the done pulse
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ADDR, ST_BURST: state_d = !ahb.Hreadyout ? state_q : last_beat ? ST_LAST : ST_BURST;
      ST_LAST:           state_d = ahb.Hreadyout ? ST_DONE : ST_LAST;
      default:           state_d = accept && !bad ? ST_ADDR : ST_IDLE;
    endcase
  end
  always_comb begin
    ahb.Htrans = state_q == ST_ADDR ? HTRANS_NONSEQ : state_q == ST_BURST ? HTRANS_SEQ : HTRANS_IDLE;
    busy       = state_q inside {ST_ADDR, ST_BURST, ST_LAST};
    done       = state_q == ST_DONE;
    cmd_ready  = (state_q == ST_IDLE || state_q == ST_DONE) && Hresetn;
  end
  // write data for a beat is loaded as its address phase is accepted
  always_comb begin
    write_d    = accept ? cmd_write : write_q;
    size_d     = accept ? cmd_size : size_q;
    len_d      = accept ? cmd_len[CW-1:0] : len_q;
    burst_d    = !accept ? burst_q : cmd_len == 3'd0 ? HBURST_SINGLE :
                 (cmd_len == 3'd3 && MAX_BEATS == 4) ? HBURST_INCR4 : HBURST_INCR;
    wdata_d    = accept ? cmd_wdata : wdata_q;
    cnt_d      = accept ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    hwdata_d   = addr_adv ? wdata_q[cnt_q] : hwdata_q;
    rd_valid_d = data_end && !write_q;
    rd_data_d  = data_end && !write_q ? ahb.Hrdata : rd_data_q;
    err_d      = accept && bad;
  end
  always_ff @(posedge Hclk or negedge Hresetn)
    if (!Hresetn) begin
      write_q    <= 1'b0;
      size_q     <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      hwdata_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      hreadyin_q <= 1'b0;
    end else begin
      write_q    <= write_d;
      size_q     <= size_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      hwdata_q   <= hwdata_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      hreadyin_q <= 1'b1;
    end
  assign ahb.Haddr    = addr_q;
  assign ahb.Hwdata   = hwdata_q;
  assign ahb.Hwrite   = write_q;
  assign ahb.Hsize    = {1'b0, size_q};
  assign ahb.Hburst   = burst_q;
  assign ahb.Hreadyin = hreadyin_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign err          = err_q;
endmodule

// File: tb/tb_ahb_master_sequencer.sv
// tb_ahb_master_sequencer: directed vector table plus wait-state and mid-burst reset sequences
module tb_ahb_master_sequencer;
  import ahb_pkg::*;
  typedef struct {
    logic             write;
    logic [31:0]      addr;
    logic [1:0]       size;
    logic [2:0]       len;
    logic [3:0][31:0] wdata;
    logic [31:0]      rdata;
    logic             exp_err;
    logic [2:0]       exp_burst;
  } vec_t;
  logic Hclk = 1'b0, Hresetn = 1'b0, cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [1:0] cmd_size = '0;
  logic [2:0] cmd_len = '0;
  logic [127:0] cmd_wdata = '0;
  logic cmd_ready, rd_valid, done, err, busy;
  logic [31:0] rd_data;
  int errors = 0, checks = 0;
  vec_t vecs[10];
  ahb_master_sequencer_if bus();
  ahb_master_sequencer dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_len   (cmd_len),
    .cmd_wdata (cmd_wdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .ahb       (bus)
  );
  always #5 Hclk = ~Hclk;
  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask
  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, tag, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [2:0] l,
                              input logic [127:0] wd, input logic [31:0] rd, input logic e, input logic [2:0] b);
    vec_t v;
    v.write = w; v.addr = a; v.size = s; v.len = l; v.wdata = wd; v.rdata = rd; v.exp_err = e; v.exp_burst = b;
    return v;
  endfunction
  task automatic issue(input vec_t v);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_size = v.size; cmd_len = v.len; cmd_wdata = v.wdata;
  endtask
  task automatic check_reset_outputs(input int tag);
    check("rst_htrans", tag, 32'(bus.Htrans), 0);
    check("rst_haddr", tag, bus.Haddr, 0);
    check("rst_hwdata", tag, bus.Hwdata, 0);
    check("rst_hwrite", tag, 32'(bus.Hwrite), 0);
    check("rst_hsize", tag, 32'(bus.Hsize), 0);
    check("rst_hburst", tag, 32'(bus.Hburst), 0);
    check("rst_hreadyin", tag, 32'(bus.Hreadyin), 0);
    check("rst_outs", tag, {27'd0, rd_valid, done, err, busy, cmd_ready}, 0);
    check("rst_rd_data", tag, rd_data, 0);
  endtask
  // zero-wait-state run: cycle c is the c-th cycle after the accepting edge
  task automatic run_vec(input int id, input vec_t v);
    int inc;
    inc = 1 << v.size;
    issue(v);
    check("cmd_ready_idle", id, 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    if (v.exp_err) begin
      check("err_pulse", id, 32'(err), 1);
      check("rej_htrans", id, 32'(bus.Htrans), 0);
      check("rej_busy", id, 32'(busy), 0);
      check("rej_ready", id, 32'(cmd_ready), 1);
      tick();
      check("err_clear", id, 32'(err), 0);
      check("rej_htrans2", id, 32'(bus.Htrans), 0);
      return;
    end
    check("hwrite", id, 32'(bus.Hwrite), 32'(v.write));
    check("hsize", id, 32'(bus.Hsize), 32'(v.size));
    check("hburst", id, 32'(bus.Hburst), 32'(v.exp_burst));
    for (int c = 1; c <= v.len + 3; c++) begin
      check("htrans", id * 100 + c, 32'(bus.Htrans), c == 1 ? 2 : c <= v.len + 1 ? 3 : 0);
      if (c <= v.len + 1) check("haddr", id * 100 + c, bus.Haddr, v.addr + 32'((c - 1) * inc));
      if (v.write && c >= 2 && c <= v.len + 2) check("hwdata", id * 100 + c, bus.Hwdata, v.wdata[c - 2]);
      check("rd_valid", id * 100 + c, 32'(rd_valid), (!v.write && c >= 3) ? 1 : 0);
      if (!v.write && c >= 3) check("rd_data", id * 100 + c, rd_data, v.rdata + 32'(c - 3));
      check("done", id * 100 + c, 32'(done), c == v.len + 3 ? 1 : 0);
      check("busy", id * 100 + c, 32'(busy), c <= v.len + 2 ? 1 : 0);
      check("cmd_ready", id * 100 + c, 32'(cmd_ready), c == v.len + 3 ? 1 : 0);
      bus.Hrdata = v.rdata + 32'(c - 2);
      tick();
    end
    check("done_clear", id, 32'(done), 0);
    check("busy_clear", id, 32'(busy), 0);
    check("htrans_idle", id, 32'(bus.Htrans), 0);
  endtask
  initial begin
    bus.Hreadyout = 1'b1;
    bus.Hrdata = '0;
    vecs[0] = mk(1, 32'h8000_0001, 0, 0, 128'h80, 0, 0, HBURST_SINGLE);
    vecs[1] = mk(0, 32'h8000_0001, 0, 0, 0, 32'h5A, 0, HBURST_SINGLE);
    vecs[2] = mk(1, 32'h8000_0001, 0, 3, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, HBURST_INCR4);
    vecs[3] = mk(0, 32'h8000_0100, 1, 1, 0, 32'h1000, 0, HBURST_INCR);
    vecs[4] = mk(1, 32'h8000_03F4, 2, 2, {32'h0, 32'hC3, 32'hB2, 32'hA1}, 0, 0, HBURST_INCR);
    vecs[5] = mk(1, 32'h8000_03F8, 2, 3, 0, 0, 1, 0);
    vecs[6] = mk(1, 32'h8000_0002, 2, 0, 0, 0, 1, 0);
    vecs[7] = mk(0, 32'h8000_0000, 3, 0, 0, 0, 1, 0);
    vecs[8] = mk(0, 32'h8000_03F0, 2, 3, 0, 32'hCAFE_0000, 0, HBURST_INCR4);
    vecs[9] = mk(0, 32'h8000_0001, 1, 1, 0, 0, 1, 0);
    repeat (2) tick();
    check_reset_outputs(0);
    #2 Hresetn = 1'b1;
    #1;
    check("ready_after_release", 0, 32'(cmd_ready), 1);
    check("hreadyin_before_edge", 0, 32'(bus.Hreadyin), 0);
    tick();
    check("hreadyin_after_edge", 0, 32'(bus.Hreadyin), 1);
    foreach (vecs[i]) run_vec(i, vecs[i]);
    // INCR4 word write, slave stalls two cycles in beat 2's data phase
    issue(mk(1, 32'h8000_0020, 2, 3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 0, HBURST_INCR4));
    repeat (4) tick();
    cmd_valid = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      bus.Hreadyout = (c == 6);
      check("ws_htrans", c, 32'(bus.Htrans), 3);
      check("ws_haddr", c, bus.Haddr, 32'h8000_002C);
      check("ws_hwdata", c, bus.Hwdata, 32'hA2);
      check("ws_done", c, 32'(done), 0);
      tick();
    end
    check("ws_last_htrans", 7, 32'(bus.Htrans), 0);
    check("ws_last_hwdata", 7, bus.Hwdata, 32'hA3);
    check("ws_last_done", 7, 32'(done), 0);
    tick();
    check("ws_done", 8, 32'(done), 1);
    tick();
    check("ws_done_clear", 9, 32'(done), 0);
    // reset during the third beat of an INCR4
    issue(mk(1, 32'h8000_0040, 2, 3, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 0, 0, HBURST_INCR4));
    repeat (3) tick();
    cmd_valid = 1'b0;
    check("mid_htrans", 3, 32'(bus.Htrans), 3);
    check("mid_haddr", 3, bus.Haddr, 32'h8000_0048);
    #2 Hresetn = 1'b0;
    #1;
    check_reset_outputs(1);
    repeat (2) tick();
    check_reset_outputs(2);
    #2 Hresetn = 1'b1;
    #1;
    check("rel_ready", 1, 32'(cmd_ready), 1);
    check("rel_hreadyin", 1, 32'(bus.Hreadyin), 0);
    tick();
    check("rel_hreadyin_edge", 1, 32'(bus.Hreadyin), 1);
    check("rel_no_resume", 1, {30'd0, busy, bus.Htrans != 2'd0}, 0);
    run_vec(20, mk(1, 32'h8000_0060, 2, 0, 128'h1234_5678, 0, 0, HBURST_SINGLE));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
